fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx.sv | 146 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// FIFO drain to UART: pops one byte at a time from a registered-read FIFO and
// serialises it LSB first as a start bit, 8 data bits and STOP_BITS stop bits.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 208,
    parameter int STOP_BITS    = 1
) (
    input  logic       i_clk,
    input  logic       i_res_n,
    input  logic       i_tx_en,
    input  logic       i_fifo_empty,
    input  logic [7:0] i_fifo_data,
    output logic       o_fifo_ren,
    output logic       o_uart_tx,
    output logic       o_busy
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [2:0]        BIT_LAST  = 3'd7;
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    state_t            state_r, state_s;
    logic [BAUD_W-1:0] baud_r, baud_s;
    logic [2:0]        bit_r, bit_s;
    logic [7:0]        shift_r, shift_s;
    logic              tx_r, tx_s;
    logic              ren_r, ren_s;
    logic              busy_r, busy_s;
    logic              baud_end_s;

    assign baud_end_s = (baud_r == BAUD_LAST);

    // Next-state logic; the bit counter also counts stop bits while in STOP.
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        tx_s    = tx_r;
        ren_s   = 1'b0;
        case (state_r)
            IDLE: begin
                tx_s   = 1'b1;
                baud_s = BAUD_ZERO;
                if (i_tx_en && !i_fifo_empty) begin
                    ren_s   = 1'b1;
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                baud_s  = BAUD_ZERO;
                state_s = LOAD;
            end
            LOAD: begin
                shift_s = i_fifo_data;
                tx_s    = 1'b0;
                baud_s  = BAUD_ZERO;
                state_s = START;
            end
            START: begin
                if (baud_end_s) begin
                    tx_s    = shift_r[0];
                    bit_s   = 3'd0;
                    baud_s  = BAUD_ZERO;
                    state_s = DATA;
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            DATA: begin
                if (baud_end_s) begin
                    baud_s  = BAUD_ZERO;
                    shift_s = {1'b0, shift_r[7:1]};
                    if (bit_r == BIT_LAST) begin
                        tx_s    = 1'b1;
                        bit_s   = 3'd0;
                        state_s = STOP;
                    end else begin
                        tx_s  = shift_r[1];
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            STOP: begin
                if (baud_end_s) begin
                    baud_s = BAUD_ZERO;
                    if (bit_r == STOP_LAST) begin
                        bit_s   = 3'd0;
                        state_s = IDLE;
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            default: begin
                tx_s    = 1'b1;
                baud_s  = BAUD_ZERO;
                bit_s   = 3'd0;
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge i_clk) begin
        if (!i_res_n) begin
            state_r <= IDLE;
            baud_r  <= BAUD_ZERO;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            tx_r    <= 1'b1;
            ren_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            tx_r    <= tx_s;
            ren_r   <= ren_s;
            busy_r  <= busy_s;
        end
    end

    assign o_fifo_ren = ren_r;
    assign o_uart_tx  = tx_r;
    assign o_busy     = busy_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (4 clk/bit 1 stop, 2 clk/bit 2 stops) fed by
// queue-based FIFO models; line traces are compared with a frame-level reference.
module tb_fifo_uart_tx;
    localparam int CPB_A = 4;
    localparam int SB_A  = 1;
    localparam int CPB_B = 2;
    localparam int SB_B  = 2;
    localparam int MAXS  = 600;

    logic       clk     = 1'b0;
    logic       res_n   = 1'b0;
    logic       en_a    = 1'b0;
    logic       en_b    = 1'b0;
    logic       empty_a = 1'b1;
    logic       empty_b = 1'b1;
    logic [7:0] data_a  = 8'h00;
    logic [7:0] data_b  = 8'h00;
    logic       ren_a, tx_a, busy_a;
    logic       ren_b, tx_b, busy_b;

    logic [7:0] fifo_a[$];
    logic [7:0] fifo_b[$];
    logic [7:0] sent_q[$];
    logic [7:0] dec_q[$];
    int         start_q[$];
    logic       tx_rec[MAXS];
    logic       ren_rec[MAXS];
    logic       busy_rec[MAXS];
    logic       tx_exp[MAXS];
    logic       ren_exp[MAXS];
    logic       busy_exp[MAXS];
    int         underflow = 0;
    int         checks = 0;
    int         errors = 0;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB_A), .STOP_BITS(SB_A)) dut_a (
        .i_clk(clk), .i_res_n(res_n), .i_tx_en(en_a), .i_fifo_empty(empty_a),
        .i_fifo_data(data_a), .o_fifo_ren(ren_a), .o_uart_tx(tx_a), .o_busy(busy_a)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB_B), .STOP_BITS(SB_B)) dut_b (
        .i_clk(clk), .i_res_n(res_n), .i_tx_en(en_b), .i_fifo_empty(empty_b),
        .i_fifo_data(data_b), .o_fifo_ren(ren_b), .o_uart_tx(tx_b), .o_busy(busy_b)
    );

    always #5 clk = ~clk;

    // Registered-read FIFO models: pop on a ren edge, data valid the next cycle.
    always @(posedge clk) begin
        if (ren_a) begin
            if (fifo_a.size() > 0) data_a <= fifo_a.pop_front();
            else underflow <= underflow + 1;
        end
        if (ren_b) begin
            if (fifo_b.size() > 0) data_b <= fifo_b.pop_front();
            else underflow <= underflow + 1;
        end
        empty_a <= (fifo_a.size() == 0);
        empty_b <= (fifo_b.size() == 0);
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic push(input int sel, input logic [7:0] b);
        if (sel == 0) fifo_a.push_back(b);
        else fifo_b.push_back(b);
        sent_q.push_back(b);
    endtask

    // Record one sample per cycle; optionally drop the enable after sample drop_at.
    task automatic capture(input int sel, input int nsamp, input int drop_at);
        for (int k = 0; k < MAXS; k++) begin
            tx_rec[k] = 1'b1; ren_rec[k] = 1'b0; busy_rec[k] = 1'b0;
        end
        for (int k = 1; k <= nsamp; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (sel == 0) begin
                tx_rec[k] = tx_a; ren_rec[k] = ren_a; busy_rec[k] = busy_a;
            end else begin
                tx_rec[k] = tx_b; ren_rec[k] = ren_b; busy_rec[k] = busy_b;
            end
            if (k == drop_at) begin
                if (sel == 0) en_a = 1'b0;
                else en_b = 1'b0;
            end
        end
    endtask

    // Reference: ren pulse, start bit two cycles later, 8 data bits LSB first,
    // stop bits, then three high cycles (idle, request, load) before the next start.
    task automatic build_model(input int cpb, input int sb, input int first_ren, input int n_frames);
        int f, r, s, idx;
        logic lvl;
        logic [7:0] b;
        for (int k = 0; k < MAXS; k++) begin
            tx_exp[k] = 1'b1; ren_exp[k] = 1'b0; busy_exp[k] = 1'b0;
        end
        f = (9 + sb) * cpb;
        r = first_ren;
        for (int i = 0; i < n_frames; i++) begin
            s = r + 2;
            b = sent_q[i];
            if (r < MAXS) ren_exp[r] = 1'b1;
            for (int k = r; k < s + f && k < MAXS; k++) busy_exp[k] = 1'b1;
            for (int p = 0; p < 9 + sb; p++) begin
                if (p == 0) lvl = 1'b0;
                else if (p <= 8) lvl = b[p - 1];
                else lvl = 1'b1;
                for (int j = 0; j < cpb; j++) begin
                    idx = s + p * cpb + j;
                    if (idx < MAXS) tx_exp[idx] = lvl;
                end
            end
            r = s + f + 1;
        end
    endtask

    function automatic int trace_diff(input int nsamp);
        for (int k = 1; k <= nsamp; k++) begin
            if (tx_rec[k] !== tx_exp[k] || ren_rec[k] !== ren_exp[k] || busy_rec[k] !== busy_exp[k])
                return k;
        end
        return 0;
    endfunction

    function automatic int count_ren(input int nsamp);
        int n = 0;
        for (int k = 1; k <= nsamp; k++) if (ren_rec[k] === 1'b1) n++;
        return n;
    endfunction

    // Plain UART receiver: falling edge, then mid-bit sampling of the data bits.
    task automatic decode(input int cpb, input int sb, input int nsamp);
        logic [7:0] b;
        int k;
        dec_q.delete();
        start_q.delete();
        k = 1;
        while (k <= nsamp) begin
            if (tx_rec[k] == 1'b0 && tx_rec[k - 1] == 1'b1 && k + (9 + sb) * cpb - 1 <= nsamp) begin
                for (int p = 0; p < 8; p++) b[p] = tx_rec[k + (p + 1) * cpb + cpb / 2];
                dec_q.push_back(b);
                start_q.push_back(k);
                k = k + (9 + sb) * cpb;
            end else begin
                k++;
            end
        end
    endtask

    task automatic test_reset();
        res_n = 1'b0;
        cycles(3);
        checks++;
        if ({tx_a, ren_a, busy_a} !== 3'b100) begin
            $display("FAIL reset_a: tx/ren/busy got %b%b%b expected 100", tx_a, ren_a, busy_a);
            errors++;
        end
        checks++;
        if ({tx_b, ren_b, busy_b} !== 3'b100) begin
            $display("FAIL reset_b: tx/ren/busy got %b%b%b expected 100", tx_b, ren_b, busy_b);
            errors++;
        end
        res_n = 1'b1;
        cycles(1);
    endtask

    task automatic test_idle_empty();
        int bad = 0;
        en_a = 1'b1;
        checks++;
        for (int i = 0; i < 100; i++) begin
            cycles(1);
            if ({tx_a, ren_a, busy_a} !== 3'b100 && bad == 0) begin
                $display("FAIL idle_empty cycle %0d: tx/ren/busy got %b%b%b expected 100", i, tx_a, ren_a, busy_a);
                errors++;
                bad = 1;
            end
        end
    endtask

    task automatic test_single_a5();
        int n, d;
        sent_q.delete();
        push(0, 8'hA5);
        n = 2 + (9 + SB_A) * CPB_A + 3 + 6;
        capture(0, n, 0);
        build_model(CPB_A, SB_A, 2, 1);
        d = trace_diff(n);
        checks++;
        if (d != 0) begin
            $display("FAIL a5_trace sample %0d: tx/ren/busy got %b%b%b expected %b%b%b",
                     d, tx_rec[d], ren_rec[d], busy_rec[d], tx_exp[d], ren_exp[d], busy_exp[d]);
            errors++;
        end
        checks++;
        if (count_ren(n) != 1) begin
            $display("FAIL a5_ren_pulses: got %0d expected 1", count_ren(n));
            errors++;
        end
        decode(CPB_A, SB_A, n);
        checks++;
        if (dec_q.size() != 1 || dec_q[0] !== 8'hA5) begin
            $display("FAIL a5_decode: got %0d frames first %h expected 1 frame a5", dec_q.size(), (dec_q.size() > 0) ? dec_q[0] : 8'hxx);
            errors++;
        end
    endtask

    // Sends the bytes already in sent_q back to back on instance A and checks everything.
    task automatic run_burst_a(input string name);
        int n, d, nb, gap;
        nb = sent_q.size();
        n = 2 + nb * ((9 + SB_A) * CPB_A + 3) + 6;
        capture(0, n, 0);
        build_model(CPB_A, SB_A, 2, nb);
        d = trace_diff(n);
        checks++;
        if (d != 0) begin
            $display("FAIL %s_trace sample %0d: tx/ren/busy got %b%b%b expected %b%b%b",
                     name, d, tx_rec[d], ren_rec[d], busy_rec[d], tx_exp[d], ren_exp[d], busy_exp[d]);
            errors++;
        end
        checks++;
        if (count_ren(n) != nb) begin
            $display("FAIL %s_ren_pulses: got %0d expected %0d", name, count_ren(n), nb);
            errors++;
        end
        decode(CPB_A, SB_A, n);
        checks++;
        if (dec_q.size() != nb) begin
            $display("FAIL %s_frame_count: got %0d expected %0d", name, dec_q.size(), nb);
            errors++;
        end else begin
            for (int i = 0; i < nb; i++) begin
                checks++;
                if (dec_q[i] !== sent_q[i]) begin
                    $display("FAIL %s_byte%0d: got %h expected %h", name, i, dec_q[i], sent_q[i]);
                    errors++;
                end
            end
        end
        checks++;
        if (fifo_a.size() != 0) begin
            $display("FAIL %s_fifo_left: got %0d expected 0", name, fifo_a.size());
            errors++;
        end
        if (nb >= 2 && sent_q[0][7] == 1'b0) begin
            gap = 0;
            if (start_q.size() >= 2)
                for (int k = start_q[1] - 1; k >= 1 && tx_rec[k] == 1'b1; k--) gap++;
            checks++;
            if (gap != SB_A * CPB_A + 3) begin
                $display("FAIL %s_gap: got %0d expected %0d", name, gap, SB_A * CPB_A + 3);
                errors++;
            end
        end
    endtask

    task automatic test_back_to_back();
        sent_q.delete();
        push(0, 8'h00);
        push(0, 8'hFF);
        push(0, 8'h55);
        run_burst_a("b2b");
    endtask

    task automatic test_random_burst();
        int nb;
        for (int it = 0; it < 3; it++) begin
            sent_q.delete();
            nb = $urandom_range(1, 4);
            for (int i = 0; i < nb; i++) push(0, 8'($urandom_range(0, 255)));
            run_burst_a("rand");
        end
    endtask

    task automatic test_en_drop();
        int n, d, drop;
        sent_q.delete();
        push(0, 8'($urandom_range(0, 255)));
        push(0, 8'($urandom_range(0, 255)));
        drop = $urandom_range(4 + CPB_A, 4 + 9 * CPB_A - 2);
        n = 2 + (9 + SB_A) * CPB_A + 3 + 10;
        capture(0, n, drop);
        build_model(CPB_A, SB_A, 2, 1);
        d = trace_diff(n);
        checks++;
        if (d != 0) begin
            $display("FAIL endrop_trace sample %0d: tx/ren/busy got %b%b%b expected %b%b%b",
                     d, tx_rec[d], ren_rec[d], busy_rec[d], tx_exp[d], ren_exp[d], busy_exp[d]);
            errors++;
        end
        checks++;
        if (fifo_a.size() != 1) begin
            $display("FAIL endrop_fifo_left: got %0d expected 1", fifo_a.size());
            errors++;
        end
        sent_q.pop_front();
        en_a = 1'b1;
        n = 1 + (9 + SB_A) * CPB_A + 3 + 6;
        capture(0, n, 0);
        build_model(CPB_A, SB_A, 1, 1);
        d = trace_diff(n);
        checks++;
        if (d != 0) begin
            $display("FAIL reenable_trace sample %0d: tx/ren/busy got %b%b%b expected %b%b%b",
                     d, tx_rec[d], ren_rec[d], busy_rec[d], tx_exp[d], ren_exp[d], busy_exp[d]);
            errors++;
        end
        decode(CPB_A, SB_A, n);
        checks++;
        if (dec_q.size() != 1 || dec_q[0] !== sent_q[0]) begin
            $display("FAIL reenable_decode: got %0d frames first %h expected 1 frame %h",
                     dec_q.size(), (dec_q.size() > 0) ? dec_q[0] : 8'hxx, sent_q[0]);
            errors++;
        end
    endtask

    task automatic test_reset_mid_frame();
        sent_q.delete();
        push(0, 8'($urandom_range(0, 255)));
        cycles(4 + CPB_A + 6);
        res_n = 1'b0;
        cycles(1);
        checks++;
        if ({tx_a, ren_a, busy_a} !== 3'b100) begin
            $display("FAIL midreset_outputs: tx/ren/busy got %b%b%b expected 100", tx_a, ren_a, busy_a);
            errors++;
        end
        res_n = 1'b1;
        cycles(5);
        checks++;
        if ({tx_a, ren_a, busy_a} !== 3'b100) begin
            $display("FAIL midreset_idle: tx/ren/busy got %b%b%b expected 100", tx_a, ren_a, busy_a);
            errors++;
        end
        sent_q.delete();
        push(0, 8'($urandom_range(0, 255)));
        run_burst_a("postreset");
    endtask

    task automatic test_two_stop();
        int n, d;
        en_b = 1'b1;
        sent_q.delete();
        push(1, 8'h3C);
        push(1, 8'($urandom_range(0, 255)));
        push(1, 8'($urandom_range(0, 255)));
        n = 2 + 3 * ((9 + SB_B) * CPB_B + 3) + 6;
        capture(1, n, 0);
        build_model(CPB_B, SB_B, 2, 3);
        d = trace_diff(n);
        checks++;
        if (d != 0) begin
            $display("FAIL stop2_trace sample %0d: tx/ren/busy got %b%b%b expected %b%b%b",
                     d, tx_rec[d], ren_rec[d], busy_rec[d], tx_exp[d], ren_exp[d], busy_exp[d]);
            errors++;
        end
        decode(CPB_B, SB_B, n);
        checks++;
        if (dec_q.size() != 3) begin
            $display("FAIL stop2_frame_count: got %0d expected 3", dec_q.size());
            errors++;
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dec_q[i] !== sent_q[i]) begin
                    $display("FAIL stop2_byte%0d: got %h expected %h", i, dec_q[i], sent_q[i]);
                    errors++;
                end
            end
        end
        checks++;
        if (fifo_b.size() != 0) begin
            $display("FAIL stop2_fifo_left: got %0d expected 0", fifo_b.size());
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_idle_empty();
        test_single_a5();
        test_back_to_back();
        test_random_burst();
        test_en_drop();
        test_reset_mid_frame();
        test_two_stop();
        checks++;
        if (underflow != 0) begin
            $display("FAIL ren_on_empty: got %0d pops of an empty FIFO expected 0", underflow);
            errors++;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
